// File: rtl/imem_loader.sv
// Purpose : boot loader that assembles a byte stream into N-bit words and writes them to instruction RAM.
// Latency : last byte of a word -> mem_we pulse on the next cycle; one word per N/8+1 cycles at best.
// Backpr. : rx_ready is registered; low in IDLE/WRITE/DONE/ERR, gaps in rx_valid stall without loss.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   start                      - one-cycle pulse, begins a session from IDLE/DONE/ERR
//   rx_data/rx_valid/rx_ready  - byte stream in (header byte = word count, then words MSB first)
//   mem_we/mem_waddr/mem_wdata - instruction RAM write port
//   cpu_hold                   - holds the core until a session completes successfully
//   load_done/load_err         - session status, level while in DONE/ERR
//   word_count                 - words written in the current session
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [N-1:0]  mem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  // Compare width wide enough for both the 8-bit target and word_count.
  localparam int CW = (AW + 1 > 8) ? AW + 1 : 8;
  localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BYTES, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BYTES, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    target;
  logic [N-1:0]  asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic          byte_acc;
  logic [N-1:0]  asm_next;
  logic [CW-1:0] wc_next;
  logic          last_word;

  assign byte_acc  = rx_valid & rx_ready;
  // Earlier bytes move up, the new byte lands in the low 8 bits.
  assign asm_next  = (asm_q << 8) | N'(rx_data);
  assign wc_next   = CW'(word_count) + CW'(1);
  assign last_word = (wc_next == CW'(target));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
      byte_cnt   <= '0;
      target     <= '0;
      asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // Write enable is a single-cycle pulse; only the BYTES->WRITE transition raises it.
      mem_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_HDR;
            rx_ready  <= 1'b1;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end

        S_HDR: begin
          if (byte_acc) begin
            if (rx_data == 8'd0 || rx_data > DEPTH_B) begin
              // Rejecting oversize counts here is what keeps mem_waddr from wrapping.
              state    <= S_ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state      <= S_BYTES;
              target     <= rx_data;
              word_count <= '0;
              mem_waddr  <= '0;
              byte_cnt   <= '0;
            end
          end
        end

        S_BYTES: begin
          if (byte_acc) begin
            asm_q <= asm_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= csum ^ rx_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt  <= '0;
              mem_wdata <= asm_next;
              mem_we    <= 1'b1;
              rx_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end

        S_WRITE: begin
          word_count <= word_count + (AW + 1)'(1);
          mem_waddr  <= mem_waddr + AW'(1);
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHK;
            rx_ready <= 1'b1;
`else
            state     <= S_DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state    <= S_BYTES;
            rx_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (byte_acc) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= S_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              // RAM already holds the words; the core simply stays held.
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : directed self-checking bench for imem_loader (N=32, AW=6, DEPTH=64).
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpr. : byte sender waits on rx_ready with a bounded cycle budget.
module tb_imem_loader;

  localparam int N     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [N-1:0]  mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [N-1:0]  wr_data[$];
  logic [7:0]    csum;

  imem_loader #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Log every RAM write seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_waddr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = (rx_ready === 1'b1);
      @(negedge clk);
      n++;
    end
    rx_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL handshake byte=%h: rx_ready=%b after 50 cycles, required 1", b, rx_ready);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], gap);
      csum = csum ^ w[i*8 +: 8];
    end
  endtask

  task automatic finish_load(input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, gap);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_waddr !== 6'd0) begin errors++; $display("FAIL reset_mem_waddr got %h want 0", mem_waddr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_status got done=%b err=%b want 0/0", load_done, load_err); end
    checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    repeat (10) @(negedge clk);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL idle_no_write got %0d writes want 0", wr_addr.size()); end
    checks++; if (cpu_hold !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL idle_outputs got hold=%b rdy=%b done=%b want 1/0/0", cpu_hold, rx_ready, load_done);
    end
  endtask

  task automatic run_two_word(input string tag, input int gap);
    clear_log();
    pulse_start();
    checks++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL %s_hdr_entry got rdy=%b hold=%b done=%b err=%b want 1/1/0/0", tag, rx_ready, cpu_hold, load_done, load_err);
    end
    csum = 8'h00;
    send_byte(8'h02, gap);
    send_word(32'h8b1f03c9, gap);
    send_word(32'hb400001f, gap);
    finish_load(gap);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL %s_write_count got %0d want 2", tag, wr_addr.size()); end
    checks++; if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h8b1f03c9) begin
      errors++; $display("FAIL %s_write0 got addr=%0d data=%h want 0 8b1f03c9", tag, wr_addr[0], wr_data[0]);
    end
    checks++; if (wr_addr[1] !== 6'd1 || wr_data[1] !== 32'hb400001f) begin
      errors++; $display("FAIL %s_write1 got addr=%0d data=%h want 1 b400001f", tag, wr_addr[1], wr_data[1]);
    end
    checks++; if (word_count !== 7'd2) begin errors++; $display("FAIL %s_word_count got %0d want 2", tag, word_count); end
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL %s_done got done=%b hold=%b err=%b rdy=%b want 1/0/0/0", tag, load_done, cpu_hold, load_err, rx_ready);
    end
    checks++; if (mem_wdata !== 32'hb400001f) begin errors++; $display("FAIL %s_wdata_hold got %h want b400001f", tag, mem_wdata); end
  endtask

  task automatic test_basic();
    run_two_word("basic", 0);
  endtask

  task automatic test_gaps();
    run_two_word("gaps", 3);
  endtask

  task automatic test_bad_header();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL hdr_zero got err=%b hold=%b rdy=%b done=%b want 1/1/0/0", load_err, cpu_hold, rx_ready, load_done);
    end
    pulse_start();
    checks++; if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL err_restart got err=%b rdy=%b want 0/1", load_err, rx_ready);
    end
    send_byte(8'h41, 0);
    checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL hdr_65 got err=%b hold=%b want 1/1", load_err, cpu_hold);
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL hdr_err_no_write got %0d writes want 0", wr_addr.size()); end
    pulse_start();
    csum = 8'h00;
    send_byte(8'h01, 0);
    send_word(32'hf8000002, 0);
    finish_load(0);
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 7'd1) begin
      errors++; $display("FAIL recover_done got done=%b hold=%b wc=%0d want 1/0/1", load_done, cpu_hold, word_count);
    end
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'hf8000002) begin
      errors++; $display("FAIL recover_write got n=%0d addr=%0d data=%h want 1 0 f8000002", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h40, 0);
    checks++; if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL hdr_depth got err=%b rdy=%b want 0/1", load_err, rx_ready);
    end
    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl got rdy=%b hold=%b we=%b done=%b err=%b want 0/1/0/0/0", rx_ready, cpu_hold, mem_we, load_done, load_err);
    end
    checks++; if (mem_waddr !== 6'd0 || mem_wdata !== 32'h0 || word_count !== 7'd0) begin
      errors++; $display("FAIL midreset_data got addr=%0d data=%h wc=%0d want 0 0 0", mem_waddr, mem_wdata, word_count);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got writes=%0d rdy=%b want 0/0", wr_addr.size(), rx_ready);
    end
    run_two_word("after_reset", 0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    pulse_start();
    csum = 8'h00;
    send_byte(8'h01, 0);
    send_word(32'hf8000002, 0);
    send_byte(8'hff, 0);
    repeat (2) @(negedge clk);
    checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL csum_bad got err=%b hold=%b done=%b want 1/1/0", load_err, cpu_hold, load_done);
    end
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'hf8000002) begin
      errors++; $display("FAIL csum_bad_write got n=%0d addr=%0d data=%h want 1 0 f8000002", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    clear_log();
    pulse_start();
    csum = 8'h00;
    send_byte(8'h01, 0);
    send_word(32'hf8000002, 0);
    finish_load(0);
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL csum_good got done=%b hold=%b err=%b want 1/0/0", load_done, cpu_hold, load_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_header();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
